alu_mdu_seq: RTL

- Parametrised, registered successor of the core's combinational integer ALU.
- Adds an iterative RV32M/RV64M multiply/divide unit behind a start/busy/done handshake.
- Sits in the execute stage. The pipeline issues one operation, stalls on busy_o, and captures result_o on done_o.
- Base ops complete in one clock. M ops complete in XLEN+2 clocks. kill_i aborts on pipeline flush.

---
 rtl/alu_mdu_seq.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_mdu_seq.sv
// Registered integer ALU: single-cycle base ops plus an optional iterative RV32M/RV64M
// multiply/divide unit behind a start/busy/done handshake.
module alu_mdu_seq #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned M_EXT = 1
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic            start_i,
   input  logic            kill_i,
   input  logic [4:0]      func_i,
   input  logic [XLEN-1:0] src1_i,
   input  logic [XLEN-1:0] src2_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

   localparam int unsigned SHW = $clog2(XLEN);

   typedef enum logic [1:0] {StIdle, StCalc, StFix} state_t;

   state_t          r_state;
   logic [SHW-1:0]  r_cnt;
   logic [2:0]      r_op;
   logic            r_neg;
   logic [XLEN-1:0] r_hi;
   logic [XLEN-1:0] r_lo;
   logic [XLEN-1:0] r_opb;
   logic            r_busy;
   logic            r_done;
   logic [XLEN-1:0] r_result;

   // ---------------- base ALU ----------------
   logic [SHW-1:0]  w_shamt;
   logic            w_ltu;
   logic            w_lt;
   logic            w_eq;
   logic [XLEN-1:0] w_alu;

   assign w_shamt = src2_i[SHW-1:0];
   assign w_ltu   = src1_i < src2_i;
   assign w_lt    = $signed(src1_i) < $signed(src2_i);
   assign w_eq    = src1_i == src2_i;

   always_comb begin
      w_alu = src1_i;
      if (!func_i[4]) begin
         case (func_i[3:0])
            4'd0:  w_alu = src1_i + src2_i;
            4'd1:  w_alu = src1_i - src2_i;
            4'd2:  w_alu = src1_i ^ src2_i;
            4'd3:  w_alu = src1_i | src2_i;
            4'd4:  w_alu = src1_i & src2_i;
            4'd5:  w_alu = {{(XLEN-1){1'b0}}, w_ltu};
            4'd6:  w_alu = {{(XLEN-1){1'b0}}, w_lt};
            4'd7:  w_alu = src1_i << w_shamt;
            4'd8:  w_alu = src1_i >> w_shamt;
            4'd9:  w_alu = $signed(src1_i) >>> w_shamt;
            4'd10: w_alu = {{(XLEN-1){1'b0}}, w_eq};
            4'd11: w_alu = {{(XLEN-1){1'b0}}, !w_eq};
            4'd12: w_alu = {{(XLEN-1){1'b0}}, !w_ltu};
            4'd13: w_alu = {{(XLEN-1){1'b0}}, !w_lt};
            4'd14: w_alu = src1_i + XLEN'(4);
            4'd15: w_alu = src1_i;
         endcase
      end
   end

   // ---------------- M-unit operand setup ----------------
   logic            w_is_mop;
   logic [2:0]      w_mop;
   logic            w_a_sgn;
   logic            w_b_sgn;
   logic            w_a_neg;
   logic            w_b_neg;
   logic [XLEN-1:0] w_a_mag;
   logic [XLEN-1:0] w_b_mag;
   logic            w_div0;
   logic            w_ovf;
   logic            w_neg;

   assign w_is_mop = (M_EXT != 0) && func_i[4];
   assign w_mop    = func_i[2:0];
   assign w_a_sgn  = (w_mop == 3'd0) || (w_mop == 3'd1) || (w_mop == 3'd2) ||
                     (w_mop == 3'd4) || (w_mop == 3'd6);
   assign w_b_sgn  = (w_mop == 3'd0) || (w_mop == 3'd1) || (w_mop == 3'd4) || (w_mop == 3'd6);
   assign w_a_neg  = w_a_sgn && src1_i[XLEN-1];
   assign w_b_neg  = w_b_sgn && src2_i[XLEN-1];
   assign w_a_mag  = w_a_neg ? -src1_i : src1_i;
   assign w_b_mag  = w_b_neg ? -src2_i : src2_i;
   assign w_div0   = w_mop[2] && (src2_i == '0);
   assign w_ovf    = w_mop[2] && !w_mop[0] && (src1_i == {1'b1, {(XLEN-1){1'b0}}}) && (&src2_i);
   // Remainder follows the dividend's sign; everything else the product/quotient sign.
   assign w_neg    = (w_mop[2] && w_mop[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);

   // ---------------- iteration step ----------------
   logic [XLEN:0]   w_msum;
   logic [XLEN:0]   w_trial;

   assign w_msum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : '0);
   assign w_trial = {r_hi, r_lo[XLEN-1]} - {1'b0, r_opb};

   // ---------------- sign fix / half select ----------------
   logic [2*XLEN-1:0] w_prod;
   logic [2*XLEN-1:0] w_prod_c;
   logic [XLEN-1:0]   w_fix;

   assign w_prod   = {r_hi, r_lo};
   assign w_prod_c = r_neg ? -w_prod : w_prod;

   always_comb begin
      w_fix = w_prod_c[XLEN-1:0];
      case (r_op)
         3'd0:                w_fix = w_prod_c[XLEN-1:0];
         3'd1, 3'd2, 3'd3:    w_fix = w_prod_c[2*XLEN-1:XLEN];
         3'd4, 3'd5:          w_fix = r_neg ? -r_lo : r_lo;
         default:             w_fix = r_neg ? -r_hi : r_hi;
      endcase
   end

   // ---------------- FSM ----------------
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_state  <= StIdle;
         r_cnt    <= '0;
         r_op     <= '0;
         r_neg    <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_opb    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_result <= '0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (start_i && !kill_i) begin
                  if (w_is_mop) begin
                     r_op   <= w_mop;
                     r_busy <= 1'b1;
                     r_cnt  <= '0;
                     // Special cases preload quotient (lo) and remainder (hi) and skip CALC.
                     if (w_div0) begin
                        r_state <= StFix;
                        r_neg   <= 1'b0;
                        r_lo    <= '1;
                        r_hi    <= src1_i;
                     end else if (w_ovf) begin
                        r_state <= StFix;
                        r_neg   <= 1'b0;
                        r_lo    <= src1_i;
                        r_hi    <= '0;
                     end else begin
                        r_state <= StCalc;
                        r_neg   <= w_neg;
                        r_hi    <= '0;
                        r_lo    <= w_a_mag;
                        r_opb   <= w_b_mag;
                     end
                  end else begin
                     r_result <= w_alu;
                     r_done   <= 1'b1;
                  end
               end
            end
            StCalc: begin
               if (kill_i) begin
                  r_state <= StIdle;
                  r_busy  <= 1'b0;
               end else begin
                  if (r_op[2]) begin
                     r_hi <= w_trial[XLEN] ? {r_hi[XLEN-2:0], r_lo[XLEN-1]} : w_trial[XLEN-1:0];
                     r_lo <= {r_lo[XLEN-2:0], !w_trial[XLEN]};
                  end else begin
                     {r_hi, r_lo} <= {w_msum, r_lo[XLEN-1:1]};
                  end
                  if (r_cnt == SHW'(XLEN - 1)) begin
                     r_state <= StFix;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            StFix: begin
               r_state <= StIdle;
               r_busy  <= 1'b0;
               if (!kill_i) begin
                  r_result <= w_fix;
                  r_done   <= 1'b1;
               end
            end
            default: begin
               r_state <= StIdle;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign busy_o   = r_busy;
   assign done_o   = r_done;
   assign result_o = r_result;

endmodule
